// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store,
// with round-robin arbitration on contention and a timeout watchdog per access.
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_req,
   input  logic [DATA_WIDTH-1:0] i_addr,
   output logic                  i_done,
   output logic                  i_err,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DATA_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [1:0]            d_maskmode,
   input  logic                  d_sext,
   output logic                  d_done,
   output logic                  d_err,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  m_req,
   output logic                  m_we,
   output logic [DATA_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic [1:0]            m_maskmode,
   output logic                  m_sext,
   input  logic                  m_ready,
   input  logic [DATA_WIDTH-1:0] m_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             last_grant;
   logic [CNT_W-1:0] tmo_cnt;
   logic             i_live;
   logic             d_live;
   logic             grant_i;
   logic             grant_d;
   logic             finish;
   logic             timed_out;

   // A requester still holding req during its own done cycle is not a new request.
   assign i_live = i_req & ~i_done;
   assign d_live = d_req & ~d_done;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      finish     = 1'b0;
      timed_out  = 1'b0;
      case (state)
         IDLE: begin
            if (i_live && (!d_live || last_grant)) begin
               grant_i    = 1'b1;
               state_next = GRANT_I;
            end else if (d_live) begin
               grant_d    = 1'b1;
               state_next = GRANT_D;
            end
         end
         GRANT_I, GRANT_D: begin
            if (m_ready) begin
               finish     = 1'b1;
               state_next = IDLE;
            end else if (tmo_cnt == CNT_LAST) begin
               finish     = 1'b1;
               timed_out  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Memory request fields are latched once at grant and held for the whole access.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_grant <= 1'b1;
         tmo_cnt    <= '0;
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_maskmode <= 2'b00;
         m_sext     <= 1'b0;
         i_done     <= 1'b0;
         i_err      <= 1'b0;
         i_rdata    <= '0;
         d_done     <= 1'b0;
         d_err      <= 1'b0;
         d_rdata    <= '0;
      end else begin
         i_done <= 1'b0;
         i_err  <= 1'b0;
         d_done <= 1'b0;
         d_err  <= 1'b0;
         if (grant_i) begin
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= i_addr;
            m_wdata    <= '0;
            m_maskmode <= 2'b10;
            m_sext     <= 1'b0;
            last_grant <= 1'b0;
            tmo_cnt    <= '0;
         end
         if (grant_d) begin
            m_req      <= 1'b1;
            m_we       <= d_we;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            m_maskmode <= d_maskmode;
            m_sext     <= d_sext;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
         end
         if ((state == GRANT_I || state == GRANT_D) && !finish) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (finish) begin
            m_req <= 1'b0;
            if (state == GRANT_I) begin
               i_done  <= 1'b1;
               i_err   <= timed_out;
               i_rdata <= timed_out ? '0 : m_rdata;
            end else begin
               d_done  <= 1'b1;
               d_err   <= timed_out;
               d_rdata <= (timed_out || m_we) ? '0 : m_rdata;
            end
         end
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported unified memory between the CPU's instruction-fetch path and its load/store path. It replaces the separate instruction and data memories of the single-cycle core with one memory port. The port can take a variable number of cycles. The block sequences each access with a req/ready handshake, gives round-robin fairness on contention, and aborts accesses that never complete using a timeout watchdog.

## Interface
- DATA_WIDTH, 32, data and address width
- TIMEOUT, 16, maximum number of grant cycles without m_ready before an abort; must be ≥2
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request; held high until i_done
- i_addr  in  DATA_WIDTH  fetch byte address; stable while i_req is high
- i_done  out  1  one-cycle completion pulse for the fetch
- i_err  out  1  high together with i_done when the fetch timed out
- i_rdata  out  DATA_WIDTH  fetched word; valid while i_done is high
- d_req  in  1  load/store request; held high until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  DATA_WIDTH  data byte address
- d_wdata  in  DATA_WIDTH  store data
- d_maskmode  in  2  00 byte, 01 half, 10 word
- d_sext  in  1  1 = zero-extend load (funct3[2] encoding)
- d_done  out  1  one-cycle completion pulse for the load/store
- d_err  out  1  high together with d_done when the load/store timed out
- d_rdata  out  DATA_WIDTH  load data; 0 for stores
- m_req, m_we  out  1  memory request and write enable
- m_addr, m_wdata  out  DATA_WIDTH  memory address and write data
- m_maskmode  out  2  passed through to memory
- m_sext  out  1  passed through to memory
- m_ready  in  1  memory completes the access in this cycle
- m_rdata  in  DATA_WIDTH  memory read data; valid when m_ready is high

## Operation
- The FSM has three states: IDLE, GRANT_I and GRANT_D.
- last_grant is a 1-bit register: 0 = instruction, 1 = data.
- IDLE: the block evaluates the masked requests.
  - Masking: while x_done is high, that same requester's x_req is ignored, because the requester may still be holding it.
  - If only one requester is asking, it is granted.
  - If both are asking, the requester that is not last_grant wins.
  - If neither is asking, the FSM stays in IDLE.
- On grant, the FSM moves to GRANT_x. In the same edge the block:
  - registers m_addr, m_we, m_wdata, m_maskmode and m_sext from the winner;
  - sets m_req = 1 and updates last_grant.
- A fetch grant forces m_we = 0, m_maskmode = 10 and m_sext = 0.
- GRANT_x, when m_ready = 1:
  - the FSM goes to IDLE and m_req clears;
  - x_rdata is captured from m_rdata, or set to 0 if the access was a store;
  - x_done is driven to 1 for exactly the next cycle, with x_err = 0.
- GRANT_x, when m_ready = 0: the FSM stays put and the timeout counter increments.
  - When the counter reaches TIMEOUT-1 and m_ready is still 0, the FSM goes to IDLE and m_req clears.
  - x_done = 1 and x_err = 1 are then driven for one cycle, with x_rdata = 0.
- The timeout counter is $clog2(TIMEOUT) bits wide and clears on every grant.
- Memory outputs hold steady for the whole grant. m_ready is ignored while m_req = 0.
- Requester inputs are sampled only at grant. Changes made during a grant have no effect.
- A requester that drops x_req before x_done is protocol-illegal. Its access still completes and x_done still pulses.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1, so the instruction side wins the first tie;
  - m_req = m_we = 0, m_addr = m_wdata = 0, m_maskmode = 0, m_sext = 0;
  - i_done = d_done = i_err = d_err = 0, i_rdata = d_rdata = 0.
- A reset in the middle of a grant drops m_req on the next edge and loses the access without a done pulse.
- Minimum latency:
  - req seen in IDLE at cycle 0 → m_req = 1 at cycle 1;
  - m_ready = 1 at cycle 1 → x_done = 1 at cycle 2.
- The block supports at most one access every 2 cycles.
- Timeout: m_req stays high for exactly TIMEOUT cycles, then x_done/x_err are high in the following cycle.
- Done cycle: the FSM is in IDLE and may grant the other requester on that same edge. Its m_req rises the cycle after done.
- A request that arrives while the other requester is granted waits. It is served next, so the wait is bounded by one access plus one cycle.

## Test plan
- Lone fetch: i_req = 1 with i_addr = 0x10, memory answers with m_ready in its first cycle and m_rdata = 0x00500093. Required: m_req high 1 cycle with m_addr = 0x10 and m_we = 0; i_done = 1 two cycles after the request, with i_rdata = 0x00500093.
- Contention after reset: i_req and d_req both rise in the same cycle. Required: instruction granted first, data second. Then hold both high continuously. Required: grants alternate I, D, I, D, with no back-to-back repeat.
- Store: d_we = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF, d_maskmode = 00, memory ready after 3 cycles. Required: m_req high 3 cycles with those values stable; d_done with d_rdata = 0 and d_err = 0.
- Timeout with TIMEOUT = 16: m_ready held at 0. Required: m_req high exactly 16 cycles; then d_done = d_err = 1 for one cycle, then a return to IDLE and service of the pending i_req.
- Reset mid-grant: assert rstn = 0 during the second cycle of GRANT_D. Required: all outputs at their reset values on the next edge, no d_done, and the first post-reset tie goes to the instruction side.
- Done masking: the requester holds x_req high through its x_done cycle while the other side is idle. Required: exactly one access is issued, not a duplicate.
